prio_irq_ctrl: RTL
==================

PRIO_IRQ_CTRL -- requirements
Module: prio_irq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 The port clk SHALL be an input, 1 bit wide, and the system clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and a synchronous, active-high reset.
REQ-004 The port irq_in SHALL be an input, 8 bits wide, and carry the raw level interrupt sources.
REQ-005 The port mask SHALL be an input, 8 bits wide, where 1 blocks the source from arbitration.
REQ-006 The port ack SHALL be an input, 1 bit wide, and be asserted by the consumer to accept the presented irq_id.
REQ-007 The port valid SHALL be an output, 1 bit wide, and indicate that irq_id holds a granted request.
REQ-008 The port irq_id SHALL be an output, 3 bits wide, and carry the index of the granted source.
REQ-009 The port pending SHALL be an output, 8 bits wide, and expose the latched request register.

Function
REQ-010 The block SHALL register irq_in every cycle into irq_prev, which is internal and 8 bits wide.
REQ-011 Edge capture: at each edge, pending SHALL be updated as (pending & ~clr) | (irq_in & ~irq_prev).
REQ-012 For REQ-011, clr SHALL be one-hot on irq_id when an ack is accepted, and zero otherwise.
REQ-013 A new rising edge on bit i in the same cycle as the clear of bit i SHALL set the bit; set wins.
REQ-014 A held-high source SHALL generate exactly one pending set per low-to-high transition.
REQ-015 Mask SHALL affect arbitration only; masked bits SHALL still latch into pending and stay latched.
REQ-016 The FSM SHALL have two states: IDLE and BUSY.
REQ-017 IDLE: if (pending & ~mask) != 0 at an edge, the block SHALL load irq_id with the index of the highest set bit, set valid=1 and go to BUSY.
REQ-018 IDLE: otherwise the block SHALL remain in IDLE with valid=0 and irq_id holding its last value.
REQ-019 Priority: bit 7 SHALL be highest and bit 0 lowest; the index SHALL be computed from registered pending, never from irq_in directly.
REQ-020 BUSY: valid and irq_id SHALL be held stable until ack=1 is sampled.
REQ-021 BUSY: changes to mask and new higher-priority requests SHALL NOT alter irq_id.
REQ-022 BUSY with ack=1 sampled: the block SHALL clear pending[irq_id] per REQ-011, set valid=0 and go to IDLE.
REQ-023 After an accepted ack, valid SHALL be low for at least one cycle before the next grant.
REQ-024 ack sampled while in IDLE (valid=0) SHALL be ignored with no state or pending change.
REQ-025 Latency: a rising edge on irq_in before edge k SHALL set pending at edge k and assert valid at edge k+1 if the FSM is IDLE and the bit is unmasked.
REQ-026 Throughput: with ack tied high, one grant SHALL be issued every 2 cycles.
REQ-027 Masked-then-unmasked: a latched masked bit SHALL be granted in the first IDLE cycle after its mask bit clears.
REQ-028 Clearing mask while pending=0 SHALL produce no grant.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set pending=0, irq_prev=0, valid=0, irq_id=3'b000 and state IDLE.
REQ-030 rst SHALL override ack and irq_in captured in the same cycle.
REQ-031 Reset asserted while in BUSY SHALL drop valid at that edge and discard all pending requests.
REQ-032 Because irq_prev resets to 0, any irq_in bit high in the first cycle after reset release SHALL be captured as an edge.

Verification
REQ-033 The bench SHALL cover basic grant: irq_in=8'b11000000 from reset, mask=0, ack held low -> pending=8'b11000000, then valid=1 and irq_id=3'b111 held indefinitely.
REQ-034 The bench SHALL cover drain order: irq_in=8'b01100110, ack tied high -> grants 6, 5, 2, 1 on alternate cycles, after which pending=0 and valid stays 0.
REQ-035 The bench SHALL cover masking: irq_in=8'b00110011 with mask=8'b00110000 -> grants 1 then 0; pending retains 8'b00110000; clearing mask -> grants 5 then 4.
REQ-036 The bench SHALL cover a BUSY hold: grant on bit 1 from 8'b00000010, ack low, then bit 7 rises -> irq_id stays 3'b001 until ack; the next grant is 3'b111.
REQ-037 The bench SHALL cover set-wins: while irq_id=4, bit 4 falls and rises again in the ack cycle -> pending[4] remains 1 and bit 4 is re-granted after the gap cycle.
REQ-038 The bench SHALL cover reset mid-operation: assert rst while valid=1 with pending=8'b01001011 -> next cycle valid=0, pending=0, irq_id=0; the first post-reset edge on bit 3 -> grant 3.

Source files
------------

// File: rtl/prio_irq_ctrl.sv
// Eight-source priority interrupt controller: rising edges latch into pending,
// the highest unmasked pending bit is granted and held until acknowledged.
module prio_irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       dbg_state
);

  // Handshake: valid stays high with irq_id stable until ack is sampled high
  // at a rising edge; that edge clears pending[irq_id] and drops valid.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_irq_prev;
  logic [7:0] r_pending;
  logic [2:0] r_irq_id;
  logic [7:0] w_eligible;
  logic [7:0] w_clr;
  logic [7:0] w_rise;
  logic [2:0] w_hi_idx;
  logic       w_grant;
  logic       w_accept;

  always_comb begin
    w_eligible = r_pending & ~mask;
    w_rise     = irq_in & ~r_irq_prev;
    w_grant    = (r_state == ST_IDLE) && (|w_eligible);
    w_accept   = (r_state == ST_BUSY) && ack;
    w_clr      = w_accept ? (8'd1 << r_irq_id) : 8'd0;
    // Ascending scan so the highest set bit is the one that sticks.
    w_hi_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_eligible[i]) w_hi_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)  w_next_state = ST_BUSY;
      ST_BUSY: if (w_accept) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Set term is OR-ed after the clear so a fresh edge wins over an ack clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_prev <= 8'd0;
      r_pending  <= 8'd0;
      r_irq_id   <= 3'd0;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if (w_grant) r_irq_id <= w_hi_idx;
    end
  end

  always_comb begin
    valid     = (r_state == ST_BUSY);
    dbg_state = (r_state == ST_BUSY);
    irq_id    = r_irq_id;
    pending   = r_pending;
  end

endmodule
